// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_pkg
//  Description : Shared types for the JTAG-to-AXI debug manager: descriptor,
//                completion record, completion status and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package jtag_pkg;

    localparam int c_AXI_ADDR_W = `AXI_ADDR_WIDTH;
    localparam int c_AXI_DATA_W = `AXI_DATA_WIDTH;
    localparam int c_AXI_STRB_W = c_AXI_DATA_W / 8;
    localparam int c_AXI_ID_W   = 4;

    // Completion status reported back to the JTAG side
    typedef enum logic [1:0] {
        TXN_OKAY    = 2'd0,
        TXN_SLVERR  = 2'd1,
        TXN_DECERR  = 2'd2,
        TXN_TIMEOUT = 2'd3
    } txn_status_t;

    // Manager FSM states
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_REPORT       = 3'd5
    } jtag_axi_mgr_st_t;

    typedef struct packed {
        logic                    start;
        logic                    wr;
        logic [2:0]              size;
        logic [c_AXI_STRB_W-1:0] wstrb;
    } s_axi_jtag_ctrl_t;

    typedef struct packed {
        logic [c_AXI_ADDR_W-1:0] addr;
        logic [c_AXI_DATA_W-1:0] data_wr;
        s_axi_jtag_ctrl_t        ctrl;
    } s_axi_jtag_info_t;

    typedef struct packed {
        logic [c_AXI_DATA_W-1:0] data_rd;
        logic [1:0]              resp;
        txn_status_t             txn_status;
    } s_axi_jtag_status_t;

    // EXOKAY is folded into OKAY: the debug path only cares about success.
    function automatic txn_status_t resp_to_status(input logic [1:0] resp);
        case (resp)
            2'b10:   return TXN_SLVERR;
            2'b11:   return TXN_DECERR;
            default: return TXN_OKAY;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_axi_mgr_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_axi_mgr_if
//  Description : Single-beat AXI4 bus bundle between the debug manager and the
//                interconnect. ID echo and RLAST are not carried: the manager
//                only ever issues one single-beat transaction with ID 0.
//  Revision    : 1.0 - initial release
// ============================================================================

interface jtag_axi_mgr_if;
    import jtag_pkg::*;

    logic [c_AXI_ID_W-1:0]   awid;
    logic [c_AXI_ADDR_W-1:0] awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [c_AXI_DATA_W-1:0] wdata;
    logic [c_AXI_STRB_W-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [c_AXI_ID_W-1:0]   arid;
    logic [c_AXI_ADDR_W-1:0] araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;

    logic [c_AXI_DATA_W-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

`default_nettype wire

// File: rtl/jtag_axi_tmo.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_axi_tmo
//  Description : Clearable, enabled transaction timeout counter with a
//                terminal-count flag raised at TIMEOUT_CYCLES-1.
//  Revision    : 1.0 - initial release
// ============================================================================

module jtag_axi_tmo #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_tc
);

    localparam int unsigned             c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0]      c_TC    = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    // Clear wins over enable so a fresh transaction always starts from zero
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == c_TC);

endmodule

`default_nettype wire

// File: rtl/jtag_axi_mgr.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_axi_mgr
//  Description : Single-outstanding AXI4 manager for the JTAG debug path. Pops
//                one descriptor, issues one single-beat read or write, pushes
//                a completion record, and times out a hung interconnect.
//  Revision    : 1.0 - initial release
// ============================================================================

module jtag_axi_mgr
    import jtag_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                req_valid_i,
    output logic                     req_ready_o,
    input  wire s_axi_jtag_info_t    req_info_i,
    output logic                     sts_valid_o,
    input  wire logic                sts_ready_i,
    output s_axi_jtag_status_t       sts_o,
    output logic                     busy_o,
    jtag_axi_mgr_if.master           axi
);

    jtag_axi_mgr_st_t        r_state;
    logic [c_AXI_ADDR_W-1:0] r_addr;
    logic [c_AXI_DATA_W-1:0] r_wdata;
    logic [2:0]              r_size;
    logic [c_AXI_STRB_W-1:0] r_wstrb;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_arvalid;
    logic                    r_rready;
    logic                    r_sts_valid;
    logic                    r_busy;
    s_axi_jtag_status_t      r_sts;

    logic                    w_accept;
    logic                    w_tmo_en;
    logic                    w_tc;
    logic                    w_aw_done;
    logic                    w_w_done;

    assign w_accept  = (r_state == ST_IDLE) && req_valid_i;
    assign w_tmo_en  = (r_state == ST_WR_ADDR_DATA) || (r_state == ST_WR_RESP) ||
                       (r_state == ST_RD_ADDR)      || (r_state == ST_RD_DATA);
    // A channel counts as done once its valid has dropped or it handshakes now
    assign w_aw_done = !r_awvalid || axi.awready;
    assign w_w_done  = !r_wvalid  || axi.wready;

    jtag_axi_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_en  (w_tmo_en),
        .o_tc  (w_tc)
    );

    // Transaction sequencer: every output except req_ready_o is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_sts_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_sts       <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_addr  <= req_info_i.addr;
                        r_wdata <= req_info_i.data_wr;
                        r_size  <= req_info_i.ctrl.size;
                        r_wstrb <= req_info_i.ctrl.wstrb;
                        // start = 0 descriptors are popped and dropped
                        if (req_info_i.ctrl.start) begin
                            r_busy <= 1'b1;
                            if (req_info_i.ctrl.wr) begin
                                r_state   <= ST_WR_ADDR_DATA;
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                            end else begin
                                r_state   <= ST_RD_ADDR;
                                r_arvalid <= 1'b1;
                            end
                        end
                    end
                end

                ST_WR_ADDR_DATA: begin
                    if (w_tc) begin
                        r_awvalid   <= 1'b0;
                        r_wvalid    <= 1'b0;
                        r_state     <= ST_REPORT;
                        r_sts_valid <= 1'b1;
                        r_sts       <= '{data_rd: '0, resp: 2'b11, txn_status: TXN_TIMEOUT};
                    end else begin
                        if (axi.awready) r_awvalid <= 1'b0;
                        if (axi.wready)  r_wvalid  <= 1'b0;
                        if (w_aw_done && w_w_done) begin
                            r_state  <= ST_WR_RESP;
                            r_bready <= 1'b1;
                        end
                    end
                end

                ST_WR_RESP: begin
                    // A response arriving on the terminal cycle still completes
                    if (axi.bvalid) begin
                        r_bready    <= 1'b0;
                        r_state     <= ST_REPORT;
                        r_sts_valid <= 1'b1;
                        r_sts       <= '{data_rd: '0, resp: axi.bresp,
                                         txn_status: resp_to_status(axi.bresp)};
                    end else if (w_tc) begin
                        r_bready    <= 1'b0;
                        r_state     <= ST_REPORT;
                        r_sts_valid <= 1'b1;
                        r_sts       <= '{data_rd: '0, resp: 2'b11, txn_status: TXN_TIMEOUT};
                    end
                end

                ST_RD_ADDR: begin
                    if (w_tc) begin
                        r_arvalid   <= 1'b0;
                        r_state     <= ST_REPORT;
                        r_sts_valid <= 1'b1;
                        r_sts       <= '{data_rd: '0, resp: 2'b11, txn_status: TXN_TIMEOUT};
                    end else if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end

                ST_RD_DATA: begin
                    if (axi.rvalid) begin
                        r_rready    <= 1'b0;
                        r_state     <= ST_REPORT;
                        r_sts_valid <= 1'b1;
                        r_sts       <= '{data_rd: axi.rdata, resp: axi.rresp,
                                         txn_status: resp_to_status(axi.rresp)};
                    end else if (w_tc) begin
                        r_rready    <= 1'b0;
                        r_state     <= ST_REPORT;
                        r_sts_valid <= 1'b1;
                        r_sts       <= '{data_rd: '0, resp: 2'b11, txn_status: TXN_TIMEOUT};
                    end
                end

                ST_REPORT: begin
                    // Hold the record stable until the status FIFO has room
                    if (sts_ready_i) begin
                        r_sts_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign sts_valid_o = r_sts_valid;
    assign sts_o       = r_sts;
    assign busy_o      = r_busy;

    assign axi.awid    = '0;
    assign axi.awaddr  = r_addr;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = r_size;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awqos   = 4'd0;
    assign axi.awvalid = r_awvalid;

    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = r_wvalid;

    assign axi.bready  = r_bready;

    assign axi.arid    = '0;
    assign axi.araddr  = r_addr;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = r_size;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arqos   = 4'd0;
    assign axi.arvalid = r_arvalid;

    assign axi.rready  = r_rready;

endmodule

`default_nettype wire
